button_conditioner: RTL and testbench

- Upstream input stage for the alarm-clock system. Conditions the raw push-button and drives the system's interrupbutton_export input with a clean, debounced level.
- Stages: 2-FF synchronizer, debounce FSM, hold timer.
- Also produces one-cycle press, release and long-press strobes, plus an optional auto-repeat strobe for fast time-setting.

---
 rtl/button_conditioner.sv | 222 ++++++++++++++++++++++
 tb/tb_button_conditioner.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-FF synchronizer, debounce FSM, hold timer and strobe generation.
// Optional auto-repeat strobe is built only when BUTTON_AUTO_REPEAT_EN is defined.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
  parameter int unsigned LONG_PRESS_CYCLES = 50000000,
  parameter int unsigned REPEAT_CYCLES     = 10000000,
  parameter bit          ACTIVE_LOW        = 1'b1
) (
  input  logic clk_clk,
  input  logic reset_reset,
  input  logic button_raw,
  output logic interrupbutton_export,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic long_held
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    PRESS_DEB   = 3'd1,
    PRESSED     = 3'd2,
    LONG_HELD   = 3'd3,
    RELEASE_DEB = 3'd4
  } state_t;

  // The reset is expected to be released synchronously to clk_clk by the
  // system reset controller; assertion may arrive at any time.
  logic [1:0]        sync_q;
  logic              sync;
  logic              p_in;

  state_t            state_q, state_d;
  logic [DEB_W-1:0]  deb_q, deb_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              ret_long_q, ret_long_d;
  logic              level_q, level_d;
  logic              long_held_q, long_held_d;
  logic              press_q, press_d;
  logic              rel_q, rel_d;
  logic              long_q, long_d;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0]  rep_q, rep_d;
  logic              rep_pulse_q, rep_pulse_d;
`else
  logic              unused_rep_cfg;
  assign unused_rep_cfg = ^REPEAT_CYCLES;
`endif

  // Polarity is folded in before the synchronizer so sync is always 1 = pressed.
  assign p_in = button_raw ^ ACTIVE_LOW;
  assign sync = sync_q[1];

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], p_in};
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q     <= IDLE;
      deb_q       <= '0;
      hold_q      <= '0;
      ret_long_q  <= 1'b0;
      level_q     <= 1'b0;
      long_held_q <= 1'b0;
      press_q     <= 1'b0;
      rel_q       <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      deb_q       <= deb_d;
      hold_q      <= hold_d;
      ret_long_q  <= ret_long_d;
      level_q     <= level_d;
      long_held_q <= long_held_d;
      press_q     <= press_d;
      rel_q       <= rel_d;
      long_q      <= long_d;
    end
  end

`ifdef BUTTON_AUTO_REPEAT_EN
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      rep_q       <= '0;
      rep_pulse_q <= 1'b0;
    end else begin
      rep_q       <= rep_d;
      rep_pulse_q <= rep_pulse_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    deb_d       = deb_q;
    hold_d      = hold_q;
    ret_long_d  = ret_long_q;
    level_d     = level_q;
    long_held_d = long_held_q;
    press_d     = 1'b0;
    rel_d       = 1'b0;
    long_d      = 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
    rep_d       = rep_q;
    rep_pulse_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (sync) begin
          state_d = PRESS_DEB;
          deb_d   = '0;
        end
      end

      PRESS_DEB: begin
        if (!sync) begin
          state_d = IDLE;
          deb_d   = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d = PRESSED;
          deb_d   = '0;
          hold_d  = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          deb_d = deb_q + DEB_W'(1);
        end
      end

      // A release edge wins over a threshold hit in the same cycle.
      PRESSED: begin
        if (!sync) begin
          state_d    = RELEASE_DEB;
          ret_long_d = 1'b0;
          deb_d      = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d     = LONG_HELD;
          hold_d      = '0;
          long_d      = 1'b1;
          long_held_d = 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
          rep_d       = '0;
`endif
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      LONG_HELD: begin
        if (!sync) begin
          state_d    = RELEASE_DEB;
          ret_long_d = 1'b1;
          deb_d      = '0;
        end else begin
`ifdef BUTTON_AUTO_REPEAT_EN
          if (rep_q == REP_LAST) begin
            rep_pulse_d = 1'b1;
            rep_d       = '0;
          end else begin
            rep_d = rep_q + REP_W'(1);
          end
`endif
        end
      end

      // hold/repeat counters stay frozen here so a bounce resumes the hold.
      RELEASE_DEB: begin
        if (sync) begin
          state_d = ret_long_q ? LONG_HELD : PRESSED;
          deb_d   = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d     = IDLE;
          deb_d       = '0;
          hold_d      = '0;
          ret_long_d  = 1'b0;
          level_d     = 1'b0;
          long_held_d = 1'b0;
          rel_d       = 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
          rep_d       = '0;
`endif
        end else begin
          deb_d = deb_q + DEB_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        deb_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  assign interrupbutton_export = level_q;
  assign press_pulse           = press_q;
  assign release_pulse         = rel_q;
  assign long_pulse            = long_q;
  assign long_held             = long_held_q;
`ifdef BUTTON_AUTO_REPEAT_EN
  assign repeat_pulse          = rep_pulse_q;
`else
  assign repeat_pulse          = 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner (DEBOUNCE=4, LONG=20, REPEAT=5, active-low button).
// Repeat expectations follow whether BUTTON_AUTO_REPEAT_EN is defined for the build.
module tb_button_conditioner;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int REP  = 5;
`ifdef BUTTON_AUTO_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic clk_clk = 1'b0;
  logic reset_reset;
  logic button_raw;
  logic interrupbutton_export;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic long_held;

  int n_checks = 0;
  int n_errors = 0;

  // clock / reset block
  always #5 clk_clk = ~clk_clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES   (DEB),
    .LONG_PRESS_CYCLES (LONG),
    .REPEAT_CYCLES     (REP),
    .ACTIVE_LOW        (1'b1)
  ) dut (
    .clk_clk               (clk_clk),
    .reset_reset           (reset_reset),
    .button_raw            (button_raw),
    .interrupbutton_export (interrupbutton_export),
    .press_pulse           (press_pulse),
    .release_pulse         (release_pulse),
    .long_pulse            (long_pulse),
    .repeat_pulse          (repeat_pulse),
    .long_held             (long_held)
  );

  // Output vector order: {level, long_held, press, release, long, repeat}
  function automatic logic [5:0] outs();
    return {interrupbutton_export, long_held, press_pulse, release_pulse, long_pulse, repeat_pulse};
  endfunction

  function automatic logic [5:0] pack(input bit level, input bit held, input bit press,
                                      input bit rel, input bit lng, input bit rpt);
    return {level, held, press, rel, lng, rpt};
  endfunction

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b ({level,held,press,rel,long,rpt})", tag, got, exp);
    end
  endtask

  // driver: one active edge, then settle away from it
  task automatic step();
    @(posedge clk_clk);
    #1;
  endtask

  initial begin
    reset_reset = 1'b1;
    button_raw  = 1'b1;
    #1;
    check("reset_t0", outs(), 6'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("reset_hold%0d", i), outs(), 6'b0);
    end
    @(negedge clk_clk);
    reset_reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("idle%0d", i), outs(), 6'b0);
    end

    // Glitch: pressed for 4 samples only, never accepted.
    for (int e = 0; e <= 12; e++) begin
      button_raw = (e < 4) ? 1'b0 : 1'b1;
      step();
      check($sformatf("glitch e=%0d", e), outs(), 6'b0);
    end

    // Clean press of 10 cycles, then steady release.
    for (int e = 0; e <= 20; e++) begin
      button_raw = (e >= 10);
      step();
      check($sformatf("clean e=%0d", e), outs(),
            pack(e >= 6 && e < 16, 1'b0, e == 6, e == 16, 1'b0, 1'b0));
    end

    // Release bounce at 10..12 freezes hold for 4 edges: long at 30 instead of 26.
    // Release seen at edge 50 coincides with a repeat threshold and must suppress it.
    for (int e = 0; e <= 58; e++) begin
      button_raw = ((e >= 10 && e <= 12) || e >= 48);
      step();
      check($sformatf("long e=%0d", e), outs(),
            pack(e >= 6 && e < 54, e >= 30 && e < 54, e == 6, e == 54, e == 30,
                 REP_ON && e > 30 && e < 50 && ((e - 30) % REP) == 0));
    end

    // Async reset while in LONG_HELD, button kept pressed throughout.
    for (int e = 0; e <= 38; e++) begin
      button_raw = 1'b0;
      step();
      check($sformatf("prerst e=%0d", e), outs(),
            pack(e >= 6, e >= 26, e == 6, 1'b0, e == 26,
                 REP_ON && e > 26 && ((e - 26) % REP) == 0));
    end
    #2;
    reset_reset = 1'b1;
    #1;
    check("rst_async", outs(), 6'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("rst_hold%0d", i), outs(), 6'b0);
    end
    @(negedge clk_clk);
    reset_reset = 1'b0;
    for (int e = 0; e <= 10; e++) begin
      step();
      check($sformatf("postrst e=%0d", e), outs(),
            pack(e >= 6, 1'b0, e == 6, 1'b0, 1'b0, 1'b0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
